vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised successor of the fixed 1440x900 VGA timer.
- All four horizontal and four vertical timing segments and both sync polarities are parameters. A clock-enable input allows pixel clocks below clk.
- A fetch pointer runs LEAD pixels ahead of the displayed pixel, to hide framebuffer/text-ROM latency.
- A runtime horizontal sync shift replaces the hardcoded 120-pixel offset. Line and frame strobes are added.
- Sits between the clock block and the pixel pipeline (framebuffer reader, text renderer, DAC).

Parameters:
- H_ACTIVE, 1440, visible pixels per line
- H_FP, 80, horizontal front porch
- H_SYNC, 107, hsync width
- H_BP, 277, horizontal back porch (H_TOTAL=1904)
- V_ACTIVE, 900, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 28, vertical back porch (V_TOTAL=932)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync
- LEAD, 2, fetch-to-display lead in pixels, legal range 1..8

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  pixel clock enable; timing advances only on clk edges with en=1
- h_shift  in  HW  sync shift left in pixels; HW=$clog2(H_TOTAL)
- fetch_x  out  HW  horizontal counter, LEAD pixels ahead of display
- fetch_y  out  VW  vertical counter, LEAD pixels ahead of display; VW=$clog2(V_TOTAL)
- fetch_valid  out  1  fetch_x<H_ACTIVE && fetch_y<V_ACTIVE
- x  out  HW  displayed pixel column
- y  out  VW  displayed pixel row
- de  out  1  display enable (can_color)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- line_start  out  1  one-clk pulse on new line
- frame_start  out  1  one-clk pulse on new frame
- frame_count  out  16  frame counter (optional feature)

Behaviour:
- Counters hc/vc (driving fetch_x/fetch_y) update only when en=1:
  - hc wraps H_TOTAL-1 -> 0.
  - vc increments on hc wrap; vc wraps V_TOTAL-1 -> 0.
- fetch_valid is a combinational decode of the registered counters.
- Per en-cycle, a decode word is built from hc/vc: {hc, vc, de, hsync, vsync}.
  - de = hc<H_ACTIVE && vc<V_ACTIVE
  - hsync asserted (HSYNC_POL) for hc in [H_ACTIVE+H_FP-s, H_ACTIVE+H_FP+H_SYNC-s), else !HSYNC_POL
  - vsync asserted (VSYNC_POL) for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else !VSYNC_POL
- s is the latched shift, clamped to H_FP so sync never overlaps active video.
  - s is sampled from h_shift only on the en-cycle where hc=H_TOTAL-1 and vc=V_TOTAL-1.
  - The new value therefore applies from the next frame's first pixel. Mid-frame changes of h_shift are ignored.
- The decode word passes through a LEAD-deep delay line that shifts only when en=1.
  - Outputs x, y, de, hsync and vsync are the last stage, so (x,y) = the (fetch_x,fetch_y) seen LEAD en-cycles earlier.
  - All outputs are registered; there is no combinational path from inputs.
- line_start: registered; high for exactly one clk after an en-edge on which the output stage takes x=0 (any y, including blanking).
- frame_start: as line_start, but requires x=0 and y=0.
- en=0: counters, delay line and outputs hold; line_start and frame_start are 0.
- en held high: the pixel rate equals clk.
- Reset (any time, overrides en):
  - hc=vc=0, s=0, frame_count=0, line_start=frame_start=0.
  - Every delay stage is loaded with the blank word: x=0, y=0, de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - The first valid frame_start occurs LEAD en-cycles after reset release.
- Reset mid-frame: immediate restart at (0,0); no partial-line recovery.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_count increments by 1 on each frame_start pulse, wraps 65535 -> 0, reset to 0.
- Undefined: frame_count is tied to 16'd0 and no counter register exists.

Decomposition:
- vga_timing_pkg holds:
  - default timing constants for 1440x900@60 and 640x480@60
  - the blank-word constant
  - the decode-word typedef {hc, vc, de, hs, vs}
- Sub-module vga_delay_line: parametrised width and depth, enable-gated shift register with synchronous load-to-constant on rst.

Test Plan:
- Defaults, en=1, h_shift=0, run 2 frames -> hsync low exactly for x in [1520,1627); vsync high for y in [901,904); de count per frame = 1296000; frame_start period = 1774528 clk.
- Defaults, check fetch alignment -> on every clk, (x,y) equals (fetch_x,fetch_y) delayed 2 cycles; fetch_valid leads de by exactly 2 cycles.
- h_shift=120 set mid-frame -> current frame unchanged; next frame hsync low for x in [1440,1547) (clamped to H_FP=80, not 120); de unchanged.
- en toggling 1,0,0,1 pattern -> outputs advance only on en=1 cycles; line_start high 1 clk per line; no pulse while en=0.
- Reset asserted at x=700, y=450 for 3 clk -> during and after: de=0, hsync=1, vsync=0; frame_start 2 en-cycles after release with x=0, y=0.
- VGA_TIMING_FRAME_CNT_EN defined, 3 frames -> frame_count 0->1->2->3; undefined -> constant 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, sync-flag type and blank-word helper for vga_timing_gen.
package vga_timing_pkg;

  localparam int VGA1440_H_ACTIVE = 1440;
  localparam int VGA1440_H_FP     = 80;
  localparam int VGA1440_H_SYNC   = 107;
  localparam int VGA1440_H_BP     = 277;
  localparam int VGA1440_V_ACTIVE = 900;
  localparam int VGA1440_V_FP     = 1;
  localparam int VGA1440_V_SYNC   = 3;
  localparam int VGA1440_V_BP     = 28;

  localparam int VGA640_H_ACTIVE  = 640;
  localparam int VGA640_H_FP      = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BP      = 48;
  localparam int VGA640_V_ACTIVE  = 480;
  localparam int VGA640_V_FP      = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BP      = 33;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vga_sync_t;

  // Blanking flags for the 1440x900 polarities (hsync active-low, vsync active-high).
  localparam vga_sync_t VGA_BLANK_SYNC_DEFAULT = '{de: 1'b0, hs: 1'b1, vs: 1'b0};

  function automatic vga_sync_t vga_blank_sync(input logic hs_pol, input logic vs_pol);
    vga_sync_t b;
    b.de = 1'b0;
    b.hs = ~hs_pol;
    b.vs = ~vs_pol;
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; synchronous reset loads every stage with RST_VAL.
module vga_delay_line #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: leading fetch pointer, runtime hsync shift, line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_count is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA1440_H_ACTIVE,
  parameter int   H_FP      = VGA1440_H_FP,
  parameter int   H_SYNC    = VGA1440_H_SYNC,
  parameter int   H_BP      = VGA1440_H_BP,
  parameter int   V_ACTIVE  = VGA1440_V_ACTIVE,
  parameter int   V_FP      = VGA1440_V_FP,
  parameter int   V_SYNC    = VGA1440_V_SYNC,
  parameter int   V_BP      = VGA1440_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   LEAD      = 2,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW        = $clog2(H_TOTAL),
  localparam int  VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [HW-1:0] h_shift,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y,
  output logic          fetch_valid,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  typedef struct packed {
    logic          vld;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    vga_sync_t     sync;
  } word_t;

  localparam int    WORD_W     = $bits(word_t);
  localparam word_t BLANK_WORD = '{vld: 1'b0, hc: '0, vc: '0,
                                   sync: vga_blank_sync(HSYNC_POL, VSYNC_POL)};

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] S_MAX    = HW'(H_FP);
  localparam logic [HW:0]   HS_BEGIN = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   VS_BEGIN = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [HW-1:0] s_q, s_d;
  word_t         fetch_word, pipe_word, out_q, out_d;
  logic [WORD_W-1:0] pipe_raw;
  logic [HW:0]   hs_lo, hs_hi;
  logic          hs_on, vs_on;
  logic          line_q, line_d, frame_q, frame_d;

  // The shift is only picked up on the very last pixel so a frame never sees two sync positions.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    s_d  = s_q;
    if (en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
          s_d  = (h_shift > S_MAX) ? S_MAX : h_shift;
        end else begin
          vc_d = vc_q + VW'(1);
        end
      end else begin
        hc_d = hc_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
      s_q  <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      s_q  <= s_d;
    end
  end

  assign fetch_x     = hc_q;
  assign fetch_y     = vc_q;
  assign fetch_valid = (hc_q < H_ACT) && (vc_q < V_ACT);

  always_comb begin
    hs_lo = HS_BEGIN - {1'b0, s_q};
    hs_hi = HS_END - {1'b0, s_q};
    hs_on = ({1'b0, hc_q} >= hs_lo) && ({1'b0, hc_q} < hs_hi);
    vs_on = ({1'b0, vc_q} >= VS_BEGIN) && ({1'b0, vc_q} < VS_END);
    fetch_word.vld     = 1'b1;
    fetch_word.hc      = hc_q;
    fetch_word.vc      = vc_q;
    fetch_word.sync.de = fetch_valid;
    fetch_word.sync.hs = hs_on ? HSYNC_POL : ~HSYNC_POL;
    fetch_word.sync.vs = vs_on ? VSYNC_POL : ~VSYNC_POL;
  end

  // LEAD-1 stages here plus the output register below give the full LEAD en-cycle lag.
  vga_delay_line #(
    .WIDTH   (WORD_W),
    .DEPTH   (LEAD - 1),
    .RST_VAL (BLANK_WORD)
  ) u_delay (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .d_i   (fetch_word),
    .q_o   (pipe_raw)
  );

  assign pipe_word = word_t'(pipe_raw);

  // Strobes fire only when a real (non-blank) word with column 0 enters the output stage.
  always_comb begin
    out_d   = en ? pipe_word : out_q;
    line_d  = en && pipe_word.vld && (pipe_word.hc == '0);
    frame_d = line_d && (pipe_word.vc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= BLANK_WORD;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign x           = out_q.hc;
  assign y           = out_q.vc;
  assign de          = out_q.vld & out_q.sync.de;
  assign hsync       = out_q.sync.hs;
  assign vsync       = out_q.sync.vs;
  assign line_start  = line_q;
  assign frame_start = frame_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule
